dbnc_decoder: RTL and testbench

- Parametrised successor to the board-level key-stepped 3-to-8 decoder: decodes an IN_W-bit selector into a 2**IN_W-bit output.
- The step input (a raw push-button) is synchronised and debounced on the system clock, not used as a clock.
- Supports one-hot and thermometer output modes; the output register updates only on an accepted debounced press.
- Sits between board switches/keys and LEDs, or any selector-driven one-hot consumer.

---
 rtl/dbnc_decoder_pkg.sv | 14 +
 rtl/dbnc_decoder_sync2.sv | 27 ++
 rtl/dbnc_decoder.sv | 136 +++++++++++++
 tb/tb_dbnc_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dbnc_decoder_pkg.sv
// Shared types and constants for the debounced, key-stepped selector decoder.
package dbnc_decoder_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERM  = 1'b1;

endpackage

// File: rtl/dbnc_decoder_sync2.sv
// Two-flop synchroniser for asynchronous board inputs, width-parametrised.
// Synchronous active-low reset clears both stages.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/dbnc_decoder.sv
// Debounced key-stepped decoder: selector -> one-hot or thermometer output, loaded once per accepted press.
// Optional macro DBNC_DECODER_UPD_CNT_EN adds an 8-bit wrapping count of output updates (upd_cnt_o).
module dbnc_decoder
    import dbnc_decoder_pkg::*;
#(
    parameter  int IN_W         = 3,
    parameter  int DEBOUNCE_CYC = 16,
    localparam int OUT_W        = 1 << IN_W,
    localparam int CNT_W        = $clog2(DEBOUNCE_CYC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_i,
    input  logic [IN_W-1:0]  sel_i,
    input  logic             mode_i,
    input  logic             en_i,
    output logic [OUT_W-1:0] out_o,
`ifdef DBNC_DECODER_UPD_CNT_EN
    output logic [7:0]       upd_cnt_o,
`endif
    output logic             upd_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

    logic             w_step_s;
    logic [IN_W-1:0]  w_sel_s;
    logic [OUT_W-1:0] w_dec;
    logic             w_accept;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_out;
    logic             r_upd;

    sync2 #(.W(1)) u_sync_step (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (step_i),
        .q_o   (w_step_s)
    );

    sync2 #(.W(IN_W)) u_sync_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sel_i),
        .q_o   (w_sel_s)
    );

    always_comb begin
        w_dec = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (mode_i == MODE_THERM) begin
                w_dec[i] = (i <= int'(w_sel_s));
            end else begin
                w_dec[i] = (i == int'(w_sel_s));
            end
        end
    end

    // The press is accepted on the edge that would move S_RISE to S_HIGH; only enabled accepts load the output.
    assign w_accept = (r_state == S_RISE) && w_step_s && (r_cnt == CNT_MAX) && en_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_out   <= '0;
            r_upd   <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                S_LOW: begin
                    if (w_step_s) begin
                        r_state <= S_RISE;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_RISE: begin
                    if (!w_step_s) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                        if (w_accept) begin
                            r_out <= w_dec;
                            r_upd <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!w_step_s) begin
                        r_state <= S_FALL;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_FALL: begin
                    if (w_step_s) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign out_o = r_out;
    assign upd_o = r_upd;

`ifdef DBNC_DECODER_UPD_CNT_EN
    logic [7:0] r_upd_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_upd_cnt <= '0;
        end else if (w_accept) begin
            r_upd_cnt <= r_upd_cnt + 8'd1;
        end
    end

    assign upd_cnt_o = r_upd_cnt;
`endif

endmodule

// File: tb/tb_dbnc_decoder.sv
// Directed self-checking bench for dbnc_decoder (IN_W = 3, DEBOUNCE_CYC = 4).
// Exercises the update counter too when DBNC_DECODER_UPD_CNT_EN is defined.
module tb_dbnc_decoder;

    localparam int IN_W  = 3;
    localparam int DC    = 4;
    localparam int OUT_W = 1 << IN_W;

    logic             clk;
    logic             rst_n;
    logic             step_i;
    logic [IN_W-1:0]  sel_i;
    logic             mode_i;
    logic             en_i;
    logic [OUT_W-1:0] out_o;
    logic             upd_o;
`ifdef DBNC_DECODER_UPD_CNT_EN
    logic [7:0]       upd_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int pulses;

    dbnc_decoder #(
        .IN_W         (IN_W),
        .DEBOUNCE_CYC (DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_i    (step_i),
        .sel_i     (sel_i),
        .mode_i    (mode_i),
        .en_i      (en_i),
        .out_o     (out_o),
`ifdef DBNC_DECODER_UPD_CNT_EN
        .upd_cnt_o (upd_cnt_o),
`endif
        .upd_o     (upd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Advance n clock edges; all sampling and driving happens 1 time unit after the edge.
    task automatic tick(input int n, inout int cnt);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (upd_o === 1'b1) cnt++;
        end
    endtask

    // Full press: set up inputs, let sel settle through the synchroniser, hold, then release.
    task automatic applyStimulus(input logic [IN_W-1:0] sel, input logic mode, input logic en,
                                 input int hold, output int cnt);
        cnt    = 0;
        sel_i  = sel;
        mode_i = mode;
        en_i   = en;
        tick(3, cnt);
        step_i = 1'b1;
        tick(hold, cnt);
        step_i = 1'b0;
        tick(10, cnt);
    endtask

    initial begin
        rst_n  = 1'b0;
        step_i = 1'b1;
        sel_i  = 3'd5;
        mode_i = 1'b0;
        en_i   = 1'b1;
        pulses = 0;

        // Reset held with the key pressed must never load the output.
        for (int k = 0; k < 3; k++) begin
            tick(1, pulses);
            checkOutput("reset_out", 32'(out_o), 32'h00);
            checkOutput("reset_upd", 32'(upd_o), 32'h0);
        end
        step_i = 1'b0;
        rst_n  = 1'b1;
        tick(4, pulses);
        checkOutput("post_reset_out", 32'(out_o), 32'h00);
        checkOutput("post_reset_upd_count", 32'(pulses), 32'd0);
        applyStimulus(3'd5, 1'b0, 1'b1, 10, pulses);
        checkOutput("reset_press_out", 32'(out_o), 32'h20);
        checkOutput("reset_press_pulses", 32'(pulses), 32'd1);

        // Latency: step_i first sampled at E0, accept lands on E6 with DC = 4.
        sel_i  = 3'd3;
        mode_i = 1'b0;
        pulses = 0;
        tick(3, pulses);
        step_i = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            tick(1, pulses);
            checkOutput($sformatf("lat_noupd_E%0d", k), 32'(upd_o), 32'h0);
        end
        tick(1, pulses);
        checkOutput("lat_upd_E6", 32'(upd_o), 32'h1);
        checkOutput("lat_out_E6", 32'(out_o), 32'h08);
        pulses = 0;
        tick(50, pulses);
        checkOutput("hold_no_repeat", 32'(pulses), 32'd0);
        step_i = 1'b0;
        tick(10, pulses);
        checkOutput("release_no_update", 32'(pulses), 32'd0);
        checkOutput("release_out_held", 32'(out_o), 32'h08);

        // Thermometer decode including both selector extremes.
        applyStimulus(3'd5, 1'b1, 1'b1, 10, pulses);
        checkOutput("therm_sel5", 32'(out_o), 32'h3F);
        checkOutput("therm_sel5_pulses", 32'(pulses), 32'd1);
        applyStimulus(3'd0, 1'b1, 1'b1, 10, pulses);
        checkOutput("therm_sel0", 32'(out_o), 32'h01);
        applyStimulus(3'd7, 1'b1, 1'b1, 10, pulses);
        checkOutput("therm_sel7", 32'(out_o), 32'hFF);
        checkOutput("therm_sel7_pulses", 32'(pulses), 32'd1);

        // Bounce: highs of 1, 2 and 3 cycles are all shorter than DC+1 and must be rejected.
        sel_i  = 3'd1;
        mode_i = 1'b0;
        pulses = 0;
        tick(3, pulses);
        for (int w = 1; w <= 3; w++) begin
            step_i = 1'b1;
            tick(w, pulses);
            step_i = 1'b0;
            tick(2, pulses);
        end
        tick(8, pulses);
        checkOutput("bounce_no_upd", 32'(pulses), 32'd0);
        checkOutput("bounce_out_held", 32'(out_o), 32'hFF);
        applyStimulus(3'd1, 1'b0, 1'b1, 10, pulses);
        checkOutput("bounce_then_press_pulses", 32'(pulses), 32'd1);
        checkOutput("bounce_then_press_out", 32'(out_o), 32'h02);

        // Enable gating, including a late enable within the same press.
        applyStimulus(3'd2, 1'b0, 1'b0, 10, pulses);
        checkOutput("gated_pulses", 32'(pulses), 32'd0);
        checkOutput("gated_out_held", 32'(out_o), 32'h02);
        pulses = 0;
        en_i   = 1'b0;
        step_i = 1'b1;
        tick(10, pulses);
        en_i = 1'b1;
        tick(10, pulses);
        step_i = 1'b0;
        tick(10, pulses);
        checkOutput("late_enable_pulses", 32'(pulses), 32'd0);
        checkOutput("late_enable_out", 32'(out_o), 32'h02);
        applyStimulus(3'd2, 1'b0, 1'b1, 10, pulses);
        checkOutput("enabled_press_out", 32'(out_o), 32'h04);
        checkOutput("enabled_press_pulses", 32'(pulses), 32'd1);

`ifdef DBNC_DECODER_UPD_CNT_EN
        rst_n = 1'b0;
        tick(2, pulses);
        rst_n = 1'b1;
        tick(2, pulses);
        checkOutput("updcnt_reset", 32'(upd_cnt_o), 32'd0);
        applyStimulus(3'd4, 1'b0, 1'b1, 8, pulses);
        checkOutput("updcnt_one", 32'(upd_cnt_o), 32'd1);
        applyStimulus(3'd4, 1'b0, 1'b0, 8, pulses);
        checkOutput("updcnt_blocked", 32'(upd_cnt_o), 32'd1);
        for (int p = 0; p < 256; p++) begin
            applyStimulus(3'(p), 1'b0, 1'b1, 8, pulses);
        end
        checkOutput("updcnt_wrap", 32'(upd_cnt_o), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
